// File: rtl/edge_event_arb_pkg.sv
// Shared types and helpers for edge_event_arbiter.
// Optional feature macro: EDGE_EVENT_ARB_TIMESTAMP_EN (adds per-event timestamps).
package edge_event_arb_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_IDX_W = 4;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    localparam int MAX_TS_W  = 32;
`endif

    // Presented event, sized for the largest configuration; the top trims it to its own widths.
    typedef struct packed {
        logic [MAX_IDX_W-1:0] ch;
        logic                 pol;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
        logic [MAX_TS_W-1:0]  ts;
`endif
    } evt_t;

    // Round-robin pick: first set request scanning ptr, ptr+1, ... modulo num_ch; -1 if none.
    function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int ptr, input int num_ch);
        int idx;
        rr_pick = -1;
        // Walk offsets from the far end so the smallest offset from ptr is the last one written.
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < num_ch) begin
                idx = ptr + k;
                if (idx >= num_ch) idx = idx - num_ch;
                if (req[idx]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/edge_event_arb_slot.sv
// One channel of edge_event_arbiter: level history, edge qualification,
// single-entry pending slot and sticky overflow flag.
// Optional feature macro: EDGE_EVENT_ARB_TIMESTAMP_EN (slot latches a timestamp at capture).
module edge_event_arb_slot
    import edge_event_arb_pkg::*;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
#(
    parameter int TS_W = 16
)
`endif
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic            d,
    input  logic            rise_en,
    input  logic            fall_en,
    input  logic            unload,
    input  logic            ovf_clr,
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    input  logic [TS_W-1:0] ts_in,
    output logic [TS_W-1:0] ts,
`endif
    output logic            pend,
    output logic            pol,
    output logic            ovf
);

    logic q;
    logic rise;
    logic fall;
    logic hit;

    assign rise = d & ~q & rise_en & en;
    assign fall = ~d & q & fall_en & en;
    assign hit  = rise | fall;

    // Track history, capture qualified edges into the slot, flag edges lost to an occupied slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
            q    <= 1'b0;
            pend <= 1'b0;
            pol  <= 1'b0;
            ovf  <= 1'b0;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
            ts   <= '0;
`endif
        end else begin
            q <= d;
            // A new edge may refill the slot in the same cycle it is unloaded (set wins over clear).
            if (hit && (!pend || unload)) begin
                pend <= 1'b1;
                pol  <= rise;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
                ts   <= ts_in;
`endif
            end else if (unload) begin
                pend <= 1'b0;
            end
            // A fresh overflow beats a simultaneous clear.
            if (hit && pend && !unload) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: per-channel edge detection with one pending event per channel,
// serialised round-robin onto a single valid/ready event port.
// Optional feature macro: EDGE_EVENT_ARB_TIMESTAMP_EN (free-running counter, evt_ts port).
module edge_event_arbiter
    import edge_event_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int TS_W   = 16,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [NUM_CH-1:0] d,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_ch,
    output logic              evt_pol,
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    output logic [TS_W-1:0]   evt_ts,
`endif
    output logic [NUM_CH-1:0] ovf,
    input  logic              ovf_clr
);

    if (NUM_CH < 2 || NUM_CH > MAX_CH || TS_W < 1) begin : g_bad_param
        $error("edge_event_arbiter: NUM_CH must be 2..16 and TS_W at least 1");
    end

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] pol;
    logic [NUM_CH-1:0] unload;
    logic [IDX_W-1:0]  rr_ptr;
    logic              load;
    logic              found;
    int                pick_idx;
    int                nxt_ptr;
    logic [IDX_W-1:0]  pick_ch;
    evt_t              pick_evt;
    evt_t              evt_q;

`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] slot_ts [NUM_CH];

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clk) begin
        if (!resetn) ts_cnt <= '0;
        else         ts_cnt <= ts_cnt + 1'b1;
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
        edge_event_arb_slot #(.TS_W(TS_W)) u_slot (
            .clk     (clk),
            .resetn  (resetn),
            .en      (en),
            .d       (d[i]),
            .rise_en (rise_en[i]),
            .fall_en (fall_en[i]),
            .unload  (unload[i]),
            .ovf_clr (ovf_clr),
            .ts_in   (ts_cnt),
            .ts      (slot_ts[i]),
            .pend    (pend[i]),
            .pol     (pol[i]),
            .ovf     (ovf[i])
        );
`else
        edge_event_arb_slot u_slot (
            .clk     (clk),
            .resetn  (resetn),
            .en      (en),
            .d       (d[i]),
            .rise_en (rise_en[i]),
            .fall_en (fall_en[i]),
            .unload  (unload[i]),
            .ovf_clr (ovf_clr),
            .pend    (pend[i]),
            .pol     (pol[i]),
            .ovf     (ovf[i])
        );
`endif
    end

    // Pick the next pending slot and decide whether the output register loads this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        unload   = '0;
        pick_evt = '0;
        load     = !evt_valid || evt_ready;
        pick_idx = rr_pick(MAX_CH'(pend), int'(rr_ptr), NUM_CH);
        found    = (pick_idx >= 0);
        pick_ch  = IDX_W'(pick_idx);
        nxt_ptr  = (pick_idx == NUM_CH - 1) ? 0 : pick_idx + 1;
        if (found) begin
            pick_evt.ch  = MAX_IDX_W'(pick_ch);
            pick_evt.pol = pol[pick_ch];
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
            pick_evt.ts  = MAX_TS_W'(slot_ts[pick_ch]);
`endif
        end
        if (load && found) unload[pick_ch] = 1'b1;
    end

    // Output register: holds while stalled, otherwise reloads from the arbiter or goes idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (found) begin
                evt_valid <= 1'b1;
                evt_q     <= pick_evt;
                rr_ptr    <= IDX_W'(nxt_ptr);
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign evt_ch  = IDX_W'(evt_q.ch);
    assign evt_pol = evt_q.pol;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    assign evt_ts  = TS_W'(evt_q.ts);
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (NUM_CH=4).
// Optional feature macro: EDGE_EVENT_ARB_TIMESTAMP_EN (adds timestamp checks).
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic [3:0] d;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_pol;
    logic [3:0] ovf;
    logic       ovf_clr;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    logic [15:0] evt_ts;
    int          ts_model = 0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
    // Expected counter value after each edge.
    always @(posedge clk) ts_model <= resetn ? ts_model + 1 : 0;
`endif

    edge_event_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .d         (d),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_pol   (evt_pol),
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        en = 1'b1; d = 4'h0; rise_en = 4'hF; fall_en = 4'h0;
        evt_ready = 1'b1; ovf_clr = 1'b0;
        do_reset();
        check("reset_valid", evt_valid, 0);
        check("reset_ch", evt_ch, 0);
        check("reset_pol", evt_pol, 0);
        check("reset_ovf", ovf, 0);

        // Single rising edge on ch2 with an idle output: valid two edges later for one cycle.
        tick();
        d = 4'b0100;
        tick();
        check("rise_lat1_valid", evt_valid, 0);
        tick();
        check("rise_valid", evt_valid, 1);
        check("rise_ch", evt_ch, 2);
        check("rise_pol", evt_pol, 1);
        tick();
        check("rise_one_cycle", evt_valid, 0);
        d = 4'b0000;
        tick();
        tick();
        check("no_fall_evt", evt_valid, 0);

        // All four channels rise together while the consumer stalls.
        do_reset();
        evt_ready = 1'b0;
        d = 4'hF;
        tick();
        check("burst_lat1", evt_valid, 0);
        tick();
        check("burst_valid", evt_valid, 1);
        check("burst_ch0", evt_ch, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_ch0", evt_ch, 0);
            check("stall_valid", evt_valid, 1);
        end
        evt_ready = 1'b1;
        tick();
        check("burst_ch1", evt_ch, 1);
        tick();
        check("burst_ch2", evt_ch, 2);
        tick();
        check("burst_ch3", evt_ch, 3);
        check("burst_ch3_valid", evt_valid, 1);
        tick();
        check("burst_drained", evt_valid, 0);
        check("burst_ovf", ovf, 0);

        // Occupy the output with a ch0 fall, then overflow ch1's slot.
        rise_en = 4'h0; fall_en = 4'b0011; evt_ready = 1'b0;
        d = 4'b1110;
        tick();
        tick();
        check("ovf_hold_ch0", evt_ch, 0);
        check("ovf_hold_pol", evt_pol, 0);
        d = 4'b1100;
        tick();
        d = 4'b1110;
        tick();
        d = 4'b1100;
        tick();
        check("ovf_set", ovf, 4'b0010);
        check("ovf_still_ch0", evt_ch, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);
        evt_ready = 1'b1;
        tick();
        check("ovf_evt_valid", evt_valid, 1);
        check("ovf_evt_ch", evt_ch, 1);
        check("ovf_evt_pol", evt_pol, 0);
        tick();
        check("ovf_single_evt", evt_valid, 0);

        // New edge on ch3 in the same cycle its slot is unloaded.
        rise_en = 4'hF; fall_en = 4'hF;
        d = 4'b0100;
        tick();
        d = 4'b1100;
        tick();
        check("setwin_first_ch", evt_ch, 3);
        check("setwin_first_pol", evt_pol, 0);
        tick();
        check("setwin_second_valid", evt_valid, 1);
        check("setwin_second_ch", evt_ch, 3);
        check("setwin_second_pol", evt_pol, 1);
        tick();
        check("setwin_done", evt_valid, 0);
        check("setwin_ovf", ovf, 0);

        // Capture disabled: toggles are ignored and no stale edge appears on re-enable.
        en = 1'b0;
        d = 4'b1101;
        tick();
        d = 4'b1100;
        tick();
        d = 4'b1101;
        tick();
        tick();
        check("en0_no_evt", evt_valid, 0);
        en = 1'b1;
        tick();
        tick();
        check("en1_stable_no_evt", evt_valid, 0);

        // Reset with an event presented and two slots pending.
        evt_ready = 1'b0;
        d = 4'b0000;
        tick();
        tick();
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_ch", evt_ch, 0);
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_ch", evt_ch, 0);
        check("rst_ovf", ovf, 0);
        evt_ready = 1'b1;
        tick();
        tick();
        check("rst_pend_cleared", evt_valid, 0);
        d = 4'b1001;
        tick();
        tick();
        check("rst_ptr_ch0", evt_ch, 0);
        tick();
        check("rst_ptr_ch3", evt_ch, 3);
        tick();
        check("rst_ptr_done", evt_valid, 0);

`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
        // Edges on ch0 and ch1 captured at counter values 10 and 12.
        d = 4'b0000;
        do_reset();
        for (int i = 0; i < 50 && ts_model != 10; i++) tick();
        check("ts_reach_10", ts_model, 10);
        d = 4'b0001;
        tick();
        tick();
        check("ts_ch0", evt_ch, 0);
        check("ts_val_10", evt_ts, 10);
        d = 4'b0011;
        tick();
        tick();
        check("ts_ch1", evt_ch, 1);
        check("ts_val_12", evt_ts, 12);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
